comp_seq_nbit: RTL and testbench
================================

Name: comp_seq_nbit

Overview:
- Sequential N-bit magnitude comparator. Consumes 2-bit slice compare results (G2/L2/E2 semantics) over multiple cycles, most-significant slice first.
- Handles operands wider than one slice with small area, using start/busy/done control.
- Terminates early on the first unequal slice.
- Sits downstream of the 2-bit comparator stage and drives control logic that needs a registered, held compare result.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; slice count NS = WIDTH/2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- start  input  1  request a compare; sampled only when idle
- P  input  WIDTH  operand P; sampled on the accepted start edge
- Q  input  WIDTH  operand Q; sampled on the accepted start edge
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- G  output  1  P > Q (registered, held)
- L  output  1  P < Q (registered, held)
- E  output  1  P == Q (registered, held)

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: state IDLE, busy=0, done=0, G=0, L=0, E=0, operand registers and slice index = 0.
- States:
  - IDLE: busy=0. A sampled start=1 latches P and Q, sets idx=NS-1, clears G/L/E to 0, sets busy=1, goes to RUN.
  - RUN: on each edge, compares slice pair P[2*idx+1:2*idx] against Q[2*idx+1:2*idx] (unsigned).
    - Slice greater: G=1, done=1, busy=0, go to IDLE.
    - Slice less: L=1, done=1, busy=0, go to IDLE.
    - Slice equal with idx=0: E=1, done=1, busy=0, go to IDLE.
    - Slice equal with idx>0: idx decrements, stay in RUN.
- Latency: done goes high k clock edges after the start edge. k = (NS - index of the first unequal slice), or k = NS if all slices are equal. Range is 1..NS.
- done is high for exactly one cycle. G/L/E hold their value until the next accepted start, or until reset.
- After any done, exactly one of G/L/E is 1. While busy=1, all three are 0.
- start while busy=1 is ignored; operands are not resampled.
- start=1 in the cycle where done=1 (state already IDLE) is accepted normally. This gives back-to-back compares with no dead cycle.
- P and Q may change freely after the start edge; only the latched copies are used.
- rst asserted mid-compare aborts immediately: all outputs return to reset values and no done is produced.
- rst and start high together: rst wins.
- Comparison is unsigned only. No X-propagation handling is required beyond standard RTL.

Test Plan:
- WIDTH=8, P=0xA5, Q=0xA5, start pulse -> busy=1 for 4 cycles; done pulses on the 4th edge after start; E=1, G=0, L=0; values held until next start.
- P=0xC0, Q=0x40 -> done on the 1st edge after start (slice3 11>01); G=1, L=0, E=0.
- P=0x1F, Q=0x2F -> slice3 equal, slice2 01<10; done on the 2nd edge; L=1.
- P=0x12, Q=0x13 -> done on the 4th edge; L=1. Then start in the done cycle with P=0x13, Q=0x12 -> accepted at once, G/L/E cleared, then G=1 after 4 edges.
- Start with P=0x00, Q=0xFF; on the next edge pulse start with P=0xFF, Q=0x00 while busy -> second start ignored; result L=1 after 1 edge.
- Start with P=0x55, Q=0x55; assert rst on the 2nd edge -> busy=0, done never pulses, G=L=E=0; a subsequent compare behaves normally.

Source files
------------

// File: rtl/comp_seq_nbit.sv
// Sequential unsigned magnitude comparator: walks WIDTH/2 two-bit slices MSB first,
// stops at the first unequal slice and holds a registered G/L/E result.
module comp_seq_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);

    localparam int NS    = WIDTH / 2;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   p_lat, p_lat_nxt;
    logic [WIDTH-1:0]   q_lat, q_lat_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               busy_nxt, done_nxt;
    logic               g_nxt, l_nxt, e_nxt;
    logic [1:0]         p_slice, q_slice;

    function automatic logic [1:0] slice_at(input logic [WIDTH-1:0] op,
                                            input logic [IDX_W-1:0] i);
        logic [1:0] r;
        r = '0;
        for (int s = 0; s < NS; s++) begin
            if (i == IDX_W'(s))
                r = op[2*s +: 2];
        end
        return r;
    endfunction

    assign p_slice = slice_at(p_lat, idx);
    assign q_slice = slice_at(q_lat, idx);

    always_comb begin
        state_nxt = state;
        p_lat_nxt = p_lat;
        q_lat_nxt = q_lat;
        idx_nxt   = idx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        g_nxt     = G;
        l_nxt     = L;
        e_nxt     = E;

        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    p_lat_nxt = P;
                    q_lat_nxt = Q;
                    idx_nxt   = IDX_W'(NS - 1);
                    g_nxt     = 1'b0;
                    l_nxt     = 1'b0;
                    e_nxt     = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Any unequal slice decides the result; equal slices fall through to the next one down.
                if (p_slice > q_slice) begin
                    g_nxt     = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (p_slice < q_slice) begin
                    l_nxt     = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (idx == '0) begin
                    e_nxt     = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p_lat <= '0;
            q_lat <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            G     <= 1'b0;
            L     <= 1'b0;
            E     <= 1'b0;
        end else begin
            state <= state_nxt;
            p_lat <= p_lat_nxt;
            q_lat <= q_lat_nxt;
            idx   <= idx_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            G     <= g_nxt;
            L     <= l_nxt;
            E     <= e_nxt;
        end
    end

endmodule

// File: tb/tb_comp_seq_nbit.sv
// Directed bench for comp_seq_nbit at WIDTH=8 with hand-computed latencies and results.
module tb_comp_seq_nbit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] P, Q;
    logic             busy, done, G, L, E;

    int n_cmp = 0;
    int n_err = 0;

    comp_seq_nbit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .P     (P),
        .Q     (Q),
        .busy  (busy),
        .done  (done),
        .G     (G),
        .L     (L),
        .E     (E)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Status vector {busy, done, G, L, E}
    function automatic logic [31:0] st();
        return {27'd0, busy, done, G, L, E};
    endfunction

    // Caller is at a negedge. Issues start, then checks every cycle up to the done cycle.
    // Returns at the negedge of the done cycle.
    task automatic run_cmp(input string tag, input logic [7:0] p, input logic [7:0] q,
                           input int k, input logic eg, input logic el, input logic ee);
        P = p; Q = q; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; P = ~p; Q = ~q;
        @(negedge clk);
        check_eq({tag, "_accept"}, st(), 32'b10000);
        for (int e = 1; e <= k; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e < k)
                check_eq({tag, "_busy"}, st(), 32'b10000);
            else
                check_eq({tag, "_done"}, st(), {27'd0, 2'b01, eg, el, ee});
        end
    endtask

    task automatic idle_hold(input string tag, input int n, input logic eg, input logic el, input logic ee);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_hold"}, st(), {27'd0, 2'b00, eg, el, ee});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; P = '0; Q = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset", st(), 32'b00000);

        // rst and start together: reset wins
        start = 1'b1; P = 8'hC0; Q = 8'h40;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_wins", st(), 32'b00000);
        start = 1'b0; rst = 1'b0;
        idle_hold("idle", 1, 1'b0, 1'b0, 1'b0);

        run_cmp("eq_a5", 8'hA5, 8'hA5, 4, 1'b0, 1'b0, 1'b1);
        idle_hold("eq_a5", 3, 1'b0, 1'b0, 1'b1);

        run_cmp("gt_c0", 8'hC0, 8'h40, 1, 1'b1, 1'b0, 1'b0);
        idle_hold("gt_c0", 1, 1'b1, 1'b0, 1'b0);

        run_cmp("lt_1f", 8'h1F, 8'h2F, 2, 1'b0, 1'b1, 1'b0);
        idle_hold("lt_1f", 1, 1'b0, 1'b1, 1'b0);

        // Back-to-back: second start issued in the done cycle
        run_cmp("lt_12", 8'h12, 8'h13, 4, 1'b0, 1'b1, 1'b0);
        run_cmp("gt_13", 8'h13, 8'h12, 4, 1'b1, 1'b0, 1'b0);
        idle_hold("gt_13", 1, 1'b1, 1'b0, 1'b0);

        // Start while busy must be ignored
        P = 8'h00; Q = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("ign_accept", st(), 32'b10000);
        P = 8'hFF; Q = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("ign_done", st(), 32'b01010);
        idle_hold("ign", 2, 1'b0, 1'b1, 1'b0);

        // Reset in mid-compare aborts without done
        P = 8'h55; Q = 8'h55; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("abort_accept", st(), 32'b10000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_rst", st(), 32'b00000);
        rst = 1'b0;
        idle_hold("abort", 4, 1'b0, 1'b0, 1'b0);

        run_cmp("post_rst", 8'h80, 8'h81, 4, 1'b0, 1'b1, 1'b0);
        run_cmp("post_gt", 8'h40, 8'h3F, 1, 1'b1, 1'b0, 1'b0);
        idle_hold("post_gt", 1, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish within bound");
        $fatal(1, "timeout");
    end

endmodule
